// File: rtl/med_filt_pkg.sv
// Shared definitions for the median-filter result path: the UART transmitter
// FSM encoding, UART frame constants and default run sizing.
package med_filt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_START_BIT,
        S_DATA_BITS,
        S_STOP_BIT,
        S_DONE
    } state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam int DEF_CLKS_PER_BIT = 868;
    localparam int DEF_NUM_SAMPLES  = 100;

endpackage

// File: rtl/med_uart_tx_baud_tick_gen.sv
// Baud-rate tick generator: counts 0..CLKS_PER_BIT-1 and pulses tick on the
// terminal count. Ports: clk, rst (sync, active high), clr (sync clear), tick.
module baud_tick_gen
    import med_filt_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == TERM);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/med_uart_tx.sv
// Drains NUM_SAMPLES bytes from the result buffer as 8N1 UART frames.
// Ports: clk, rst, start | rd_en, rd_addr, rd_data | tx, busy, done, byte_count.
module med_uart_tx
    import med_filt_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES,
    parameter int BASE_ADDR    = 1,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] byte_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_SAMPLES);
    localparam logic [2:0] LAST_DBIT = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_SBIT = 3'(STOP_BITS - 1);

    state_t            state;
    logic [7:0]        shreg;
    logic [2:0]        bit_idx;
    logic              tick;
    logic              baud_clr;
    logic [ADDR_W-1:0] cnt_nxt;

    // Restart the bit timer so the start bit gets a full period.
    assign baud_clr = (state == S_LATCH);
    assign cnt_nxt  = byte_count + 1'b1;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (baud_clr),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tx         <= IDLE_LEVEL;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= BASE;
            byte_count <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= IDLE_LEVEL;
                    if (start) begin
                        rd_addr    <= BASE;
                        byte_count <= '0;
                        busy       <= 1'b1;
                        rd_en      <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    shreg <= rd_data;
                    tx    <= 1'b0;
                    state <= S_START_BIT;
                end
                S_START_BIT: begin
                    if (tick) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= S_DATA_BITS;
                    end
                end
                S_DATA_BITS: begin
                    if (tick) begin
                        if (bit_idx == LAST_DBIT) begin
                            tx      <= IDLE_LEVEL;
                            bit_idx <= '0;
                            state   <= S_STOP_BIT;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_STOP_BIT: begin
                    if (tick) begin
                        if (bit_idx == LAST_SBIT) begin
                            byte_count <= cnt_nxt;
                            if (cnt_nxt == LAST) begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                rd_addr <= rd_addr + 1'b1;
                                rd_en   <= 1'b1;
                                state   <= S_FETCH;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_med_uart_tx.sv
// Bench for med_uart_tx: cycle-by-cycle frame-schedule model, UART decoder,
// directed scenarios and randomized start/reset stimulus.
module tb_med_uart_tx;

    localparam int CPB     = 4;
    localparam int NS      = 3;
    localparam int FRAME   = 10 * CPB + 2;
    localparam int RUN_LEN = NS * FRAME + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;
    logic       done;
    logic [7:0] byte_count;

    always #5 clk = ~clk;

    med_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .NUM_SAMPLES (NS),
        .BASE_ADDR   (1),
        .ADDR_W      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .tx        (tx),
        .busy      (busy),
        .done      (done),
        .byte_count(byte_count)
    );

    logic [7:0] mem [1:NS];

    always @(posedge clk) begin
        if (rd_en && rd_addr >= 1 && rd_addr <= NS)
            rd_data <= mem[rd_addr];
        else
            rd_data <= 8'($urandom);
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;

    bit         m_act = 1'b0;
    int         m_k = 0;
    logic [7:0] m_hold_addr = 8'd1;
    logic [7:0] m_hold_cnt = 8'd0;

    logic [7:0] rx_q [$];
    logic [7:0] rx_sh;
    int         rx_cnt = -1;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                rx_cnt = -1;
            end else if (rx_cnt < 0) begin
                if (!tx) rx_cnt = 0;
            end else begin
                rx_cnt++;
                if (rx_cnt > CPB && rx_cnt < 9 * CPB && rx_cnt % CPB == 1)
                    rx_sh[rx_cnt / CPB - 1] = tx;
                if (rx_cnt == 9 * CPB + 1) begin
                    if (tx) rx_q.push_back(rx_sh);
                    rx_cnt = -1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic s, input logic r);
        if (r) begin
            m_act       = 1'b0;
            m_hold_addr = 8'd1;
            m_hold_cnt  = 8'd0;
        end else if (m_act) begin
            m_k++;
            if (m_k > RUN_LEN) begin
                m_act = 1'b0;
            end else if (m_k == RUN_LEN) begin
                m_hold_addr = 8'(NS);
                m_hold_cnt  = 8'(NS);
            end
        end else if (s) begin
            m_act = 1'b1;
            m_k   = 1;
        end
    endtask

    task automatic compare();
        int         b, p, bitn;
        logic [7:0] v;
        logic       e_tx, e_busy, e_done, e_rden;
        logic [7:0] e_addr, e_cnt;
        e_tx   = 1'b1;
        e_busy = 1'b0;
        e_done = 1'b0;
        e_rden = 1'b0;
        e_addr = m_hold_addr;
        e_cnt  = m_hold_cnt;
        if (m_act && m_k < RUN_LEN) begin
            b      = (m_k - 1) / FRAME;
            p      = (m_k - 1) % FRAME;
            e_busy = 1'b1;
            e_rden = (p == 0);
            e_addr = 8'(1 + b);
            e_cnt  = 8'(b);
            if (p >= 2) begin
                bitn = (p - 2) / CPB;
                v    = mem[1 + b];
                if (bitn == 0) e_tx = 1'b0;
                else if (bitn <= 8) e_tx = v[bitn - 1];
            end
        end else if (m_act) begin
            e_done = 1'b1;
        end
        chk("tx", int'(tx), int'(e_tx));
        chk("busy", int'(busy), int'(e_busy));
        chk("done", int'(done), int'(e_done));
        chk("rd_en", int'(rd_en), int'(e_rden));
        chk("rd_addr", int'(rd_addr), int'(e_addr));
        chk("byte_count", int'(byte_count), int'(e_cnt));
    endtask

    task automatic step(input logic s, input logic r);
        start = s;
        rst   = r;
        @(posedge clk);
        model_edge(s, r);
        @(negedge clk);
        cyc++;
        compare();
        if (done) done_seen++;
    endtask

    logic [7:0] exp_b [3];
    logic [7:0] pat;
    int         done_k;
    bit         had_rst;
    int         guard;

    initial begin
        start = 1'b0;
        rst   = 1'b1;
        exp_b[0] = 8'h7D;
        exp_b[1] = 8'hE0;
        exp_b[2] = 8'h5B;
        mem[1] = 8'h7D;
        mem[2] = 8'hE0;
        mem[3] = 8'h5B;
        @(negedge clk);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("idle_rd_addr", int'(rd_addr), 1);

        // Run A: plain run with literal timing pins.
        rx_q.delete();
        done_seen = 0;
        done_k = -1;
        pat = 8'h7D;
        step(1'b1, 1'b0);
        chk("c1_rd_en", int'(rd_en), 1);
        chk("c1_rd_addr", int'(rd_addr), 1);
        for (int k = 1; k < 140; k++) begin
            step(1'b0, 1'b0);
            if (k + 1 == 2) chk("c2_tx", int'(tx), 1);
            if (k + 1 == 3) chk("c3_tx", int'(tx), 0);
            if (k + 1 == 6) chk("c6_tx", int'(tx), 0);
            if (k + 1 >= 7 && k + 1 <= 38 && (k + 1 - 7) % CPB == 1)
                chk("c_data", int'(tx), int'(pat[(k + 1 - 7) / CPB]));
            if (k + 1 == 39) chk("c39_tx", int'(tx), 1);
            if (done && done_k < 0) done_k = k + 1;
        end
        chk("a_done_cnt", done_seen, 1);
        chk("a_done_at", done_k, 127);
        chk("a_byte_count", int'(byte_count), 3);
        chk("a_rx_size", rx_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("a_rx_byte", (i < rx_q.size()) ? int'(rx_q[i]) : -1,
                int'(exp_b[i]));

        // Run B: start re-pulsed while busy, including the DONE cycle.
        rx_q.delete();
        done_seen = 0;
        step(1'b1, 1'b0);
        for (int k = 1; k < 140; k++)
            step(k == 10 || k == 60 || k == 127, 1'b0);
        chk("b_done_cnt", done_seen, 1);
        chk("b_rx_size", rx_q.size(), 3);

        // Run C: reset mid-frame, then a fresh run.
        step(1'b1, 1'b0);
        for (int k = 1; k < 20; k++) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("c_rst_tx", int'(tx), 1);
        chk("c_rst_busy", int'(busy), 0);
        chk("c_rst_cnt", int'(byte_count), 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rx_q.delete();
        step(1'b1, 1'b0);
        for (int k = 1; k < 140; k++) step(1'b0, 1'b0);
        chk("c_first_byte", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 'h7D);

        // Run D: start and rst together.
        step(1'b1, 1'b1);
        chk("d_busy", int'(busy), 0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        chk("d_busy_later", int'(busy), 0);
        chk("d_rd_en", int'(rd_en), 0);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            for (int i = 1; i <= NS; i++) mem[i] = 8'($urandom);
            rx_q.delete();
            had_rst = 1'b0;
            step(1'b1, 1'b0);
            for (int k = 1; k < 160; k++) begin
                logic s, rr;
                s  = ($urandom_range(0, 15) == 0);
                rr = (r % 2 == 1) && ($urandom_range(0, 199) == 0);
                if (rr) had_rst = 1'b1;
                step(s, rr);
            end
            guard = 0;
            while (m_act && guard < 200) begin
                step(1'b0, 1'b0);
                guard++;
            end
            chk("rand_drain", int'(m_act), 0);
            if (!had_rst) begin
                chk("rand_rx_min3", int'(rx_q.size() >= 3), 1);
                for (int i = 0; i < 3; i++)
                    chk("rand_rx_byte",
                        (i < rx_q.size()) ? int'(rx_q[i]) : -1,
                        int'(mem[i + 1]));
            end
            for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
